// File: rtl/axi_arbiter_2x1_if.sv
// AXI-lite style bus bundle shared by both arbiter masters and the downstream slave port.
// The master modport is the initiating side; the slave modport is the responding side.
interface axi_arbiter_2x1_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_arbiter_2x1.sv
// Two-master to one-slave arbiter: m0 instruction-fetch reads, m1 load/store reads and writes,
// one transaction outstanding downstream. Define ARB_RR_EN for round-robin, else fixed priority.
module axi_arbiter_2x1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_arbiter_2x1_if.slave  m0,
  axi_arbiter_2x1_if.slave  m1,
  axi_arbiter_2x1_if.master s
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_WR1  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t     state_r;
  state_t     grant_s;
  logic       ar_done_r;
  logic       aw_done_r;
  logic       w_done_r;
  logic       both_done_s;
  logic [2:0] req_s;
  logic       unused_m0_wr_s;

  // m0 is read-only; its write channel is tied off and never observed.
  assign unused_m0_wr_s = ^{m0.awaddr, m0.awvalid, m0.wdata, m0.wstrb, m0.wvalid, m0.bready};

  assign req_s       = {m1.awvalid | m1.wvalid, m1.arvalid, m0.arvalid};
  assign both_done_s = aw_done_r & w_done_r;

`ifdef ARB_RR_EN
  // Request slot index (0 = m0 read, 1 = m1 read, 2 = m1 write) to its grant state
  function automatic state_t idx_to_state(input logic [1:0] idx);
    state_t st;
    case (idx)
      2'd0:    st = ST_RD0;
      2'd1:    st = ST_RD1;
      2'd2:    st = ST_WR1;
      default: st = ST_IDLE;
    endcase
    return st;
  endfunction

  logic [1:0] rr_ptr_r;
  logic [1:0] first_s;
  logic [1:0] second_s;
  logic [1:0] third_s;

  // Round-robin search starting at the slot the pointer names
  always_comb begin
    first_s  = rr_ptr_r;
    second_s = 2'd1;
    third_s  = 2'd2;
    case (rr_ptr_r)
      2'd1: begin
        second_s = 2'd2;
        third_s  = 2'd0;
      end
      2'd2: begin
        second_s = 2'd0;
        third_s  = 2'd1;
      end
      default: begin
        first_s  = 2'd0;
        second_s = 2'd1;
        third_s  = 2'd2;
      end
    endcase
    if (req_s[first_s]) begin
      grant_s = idx_to_state(first_s);
    end else if (req_s[second_s]) begin
      grant_s = idx_to_state(second_s);
    end else if (req_s[third_s]) begin
      grant_s = idx_to_state(third_s);
    end else begin
      grant_s = ST_IDLE;
    end
  end

  // Pointer moves past the winner so the latest winner drops to lowest priority
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_r <= 2'd0;
    end else if (state_r == ST_IDLE) begin
      case (grant_s)
        ST_RD0:  rr_ptr_r <= 2'd1;
        ST_RD1:  rr_ptr_r <= 2'd2;
        ST_WR1:  rr_ptr_r <= 2'd0;
        default: rr_ptr_r <= rr_ptr_r;
      endcase
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Fixed priority: m1 write, then m1 read, then m0 read
  always_comb begin
    if (req_s[2]) begin
      grant_s = ST_WR1;
    end else if (req_s[1]) begin
      grant_s = ST_RD1;
    end else if (req_s[0]) begin
      grant_s = ST_RD0;
    end else begin
      grant_s = ST_IDLE;
    end
  end
`endif

  // FSM state and per-channel done flags; flags clear whenever IDLE is entered or occupied
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r   <= ST_IDLE;
      ar_done_r <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r   <= grant_s;
          ar_done_r <= 1'b0;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end
        ST_RD0, ST_RD1: begin
          if (s.rvalid && s.rready) begin
            state_r   <= ST_IDLE;
            ar_done_r <= 1'b0;
          end else if (s.arvalid && s.arready) begin
            ar_done_r <= 1'b1;
          end else begin
            ar_done_r <= ar_done_r;
          end
        end
        ST_WR1: begin
          if (s.bvalid && s.bready) begin
            state_r   <= ST_IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
          end else begin
            if (s.awvalid && s.awready) begin
              aw_done_r <= 1'b1;
            end else begin
              aw_done_r <= aw_done_r;
            end
            if (s.wvalid && s.wready) begin
              w_done_r <= 1'b1;
            end else begin
              w_done_r <= w_done_r;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          ar_done_r <= 1'b0;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Channel routing: only the granted master is connected; everything else is held at zero
  always_comb begin
    s.araddr   = ADDR_ZERO;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awaddr   = ADDR_ZERO;
    s.awvalid  = 1'b0;
    s.wdata    = DATA_ZERO;
    s.wstrb    = 8'h00;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;

    m0.arready = 1'b0;
    m0.rdata   = DATA_ZERO;
    m0.rresp   = 2'b00;
    m0.rvalid  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bresp   = 2'b00;
    m0.bvalid  = 1'b0;

    m1.arready = 1'b0;
    m1.rdata   = DATA_ZERO;
    m1.rresp   = 2'b00;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bresp   = 2'b00;
    m1.bvalid  = 1'b0;

    case (state_r)
      ST_RD0: begin
        s.araddr   = m0.araddr;
        s.arvalid  = m0.arvalid & ~ar_done_r;
        m0.arready = s.arready & ~ar_done_r;
        m0.rdata   = s.rdata;
        m0.rresp   = s.rresp;
        m0.rvalid  = s.rvalid;
        s.rready   = m0.rready;
      end
      ST_RD1: begin
        s.araddr   = m1.araddr;
        s.arvalid  = m1.arvalid & ~ar_done_r;
        m1.arready = s.arready & ~ar_done_r;
        m1.rdata   = s.rdata;
        m1.rresp   = s.rresp;
        m1.rvalid  = s.rvalid;
        s.rready   = m1.rready;
      end
      ST_WR1: begin
        s.awaddr   = m1.awaddr;
        s.awvalid  = m1.awvalid & ~aw_done_r;
        m1.awready = s.awready & ~aw_done_r;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wvalid   = m1.wvalid & ~w_done_r;
        m1.wready  = s.wready & ~w_done_r;
        // The write response is only meaningful once both address and data are in.
        m1.bresp   = both_done_s ? s.bresp : 2'b00;
        m1.bvalid  = s.bvalid & both_done_s;
        s.bready   = m1.bready & both_done_s;
      end
      default: begin
        s.arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/axi_arbiter_2x1.md
AXI_ARBITER_2X1 -- requirements
Module: axi_arbiter_2x1

Interface
REQ-001 Parameter ADDR_W, default 32, sets the address width of all ar/aw address buses.
REQ-002 Parameter DATA_W, default 32, sets the width of rdata/wdata; wstrb SHALL be 8 bits and rresp/bresp 2 bits.
REQ-003 aclk  in  1  single clock; all state SHALL be sampled on posedge aclk.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 m0_araddr/m0_arvalid in, m0_arready out  ADDR_W/1/1  instruction-fetch read address channel.
REQ-006 m0_rdata/m0_rresp/m0_rvalid out, m0_rready in  DATA_W/2/1/1  instruction-fetch read data channel.
REQ-007 m1_ar*, m1_r*  same directions and widths as m0  load/store read channels.
REQ-008 m1_awaddr/m1_awvalid/m1_wdata/m1_wstrb/m1_wvalid/m1_bready in; m1_awready/m1_wready/m1_bvalid/m1_bresp out  load/store write channels.
REQ-009 s_ar*, s_r*, s_aw*, s_w*, s_b*  mirrored directions  single downstream port to the SRAM slave.

Function
REQ-010 States SHALL be IDLE, RD0 (m0 read), RD1 (m1 read) and WR1 (m1 write); exactly one transaction SHALL be outstanding on the slave port.
REQ-011 Requests: q0=m0_arvalid, q1=m1_arvalid, qw=m1_awvalid|m1_wvalid; arbitration SHALL occur only in IDLE, and the winner's state SHALL be entered on the next edge.
REQ-012 In IDLE all slave valids and all master readies/valids SHALL be 0, so a request sampled at edge N SHALL drive the slave valid from cycle N+1.
REQ-013 In RDx: s_araddr/s_arvalid SHALL be forwarded combinationally from master x, gated by a registered ar_done flag set on s_arvalid&&s_arready; mx_arready=s_arready&&!ar_done.
REQ-014 In RDx: s_rdata/s_rresp/s_rvalid SHALL route to master x and s_rready=mx_rready; on s_rvalid&&s_rready the FSM SHALL return to IDLE.
REQ-015 In WR1: aw and w SHALL be forwarded independently, each gated by its own done flag (aw_done, w_done); b SHALL route to m1, and s_bvalid&&s_bready SHALL return the FSM to IDLE.
REQ-016 AW and W in the same cycle, or in either order, SHALL both be accepted; b SHALL be forwarded only after both are done.
REQ-017 A non-granted master SHALL see arready/awready/wready/rvalid/bvalid = 0; its address and data SHALL NOT reach the slave.
REQ-018 Done flags SHALL clear on entry to IDLE; a grant SHALL never change before its response handshake completes.
REQ-019 A master's valid held continuously across a completed transaction SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-020 On aresetn low (asynchronous): state=IDLE, all done flags=0, round-robin pointer=m0, every valid/ready output=0, every data/resp output=0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction; no response SHALL be forwarded after reset release.

Configuration
REQ-022 With ARB_RR_EN defined: round-robin among {m0 read, m1 read, m1 write}; the last winner becomes lowest priority; the pointer updates on grant.
REQ-023 Without ARB_RR_EN: fixed priority m1 write > m1 read > m0 read, and no pointer register exists.

Verification
REQ-024 Single m0 read of 0x80000000 with a 1-cycle slave -> s_arvalid at N+1, m0_rvalid with slave data, IDLE after the rready handshake, m1 outputs idle throughout.
REQ-025 m0 and m1 arvalid asserted in the same cycle, ARB_RR_EN defined -> m0 served first after reset, then m1; with the macro undefined -> m1 first.
REQ-026 m1 write: awaddr 0x80001000, wdata 0xDEADBEEF, wstrb 0x0F, W two cycles before AW -> single slave write, m1_bvalid with bresp 0, then IDLE.
REQ-027 m0_rready held low for 5 cycles with s_rvalid high -> s_rvalid and data held, m1_arvalid not granted until the handshake.
REQ-028 aresetn pulsed low during RD1 after ar_done -> all outputs 0 immediately, IDLE after release, no stale m1_rvalid.
